// File: rtl/memory_bank_pipelined.sv
// rtl/memory_bank_pipelined.sv - line-granular memory bank with fixed access latency
// One request in flight; byte-masked writes commit and respond on the BUSY->RESP edge.
module memory_bank_pipelined #(
  parameter int MEMORY_LINE_LENGTH  = 256,
  parameter int MEMORY_ADDRESS_SIZE = 2,
  parameter int LATENCY             = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [MEMORY_ADDRESS_SIZE-1:0]    req_addr,
  input  logic [0:MEMORY_LINE_LENGTH-1]     req_data,
  input  logic [0:MEMORY_LINE_LENGTH/8-1]   req_be,
  output logic                              resp_valid,
  output logic                              resp_write,
  output logic [0:MEMORY_LINE_LENGTH-1]     resp_data
);

  localparam int NB    = MEMORY_LINE_LENGTH / 8;
  localparam int DEPTH = 2 ** MEMORY_ADDRESS_SIZE;
  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              write_q;
  logic [MEMORY_ADDRESS_SIZE-1:0]    addr_q;
  logic [0:MEMORY_LINE_LENGTH-1]     data_q;
  logic [0:NB-1]                     be_q;
  logic [0:MEMORY_LINE_LENGTH-1]     mem_q [DEPTH];
  logic                              resp_write_q;
  logic [0:MEMORY_LINE_LENGTH-1]     resp_data_q;
  logic [0:MEMORY_LINE_LENGTH-1]     merged_line;
  logic                              accept;
  logic                              commit;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_write = resp_write_q;
  assign resp_data  = resp_data_q;
  assign accept     = (state_q == IDLE) && req_valid;
  assign commit     = (state_q == BUSY) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BUSY;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_LAST) state_d = RESP;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads pass the line through unchanged, so one merge path serves both kinds of access.
  always_comb begin
    merged_line = mem_q[addr_q];
    for (int i = 0; i < NB; i++) begin
      if (write_q && be_q[i]) merged_line[8*i +: 8] = data_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      be_q         <= '0;
      resp_write_q <= 1'b0;
      resp_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        data_q  <= req_data;
        be_q    <= req_be;
      end
      if (commit) begin
        mem_q[addr_q] <= merged_line;
        resp_data_q   <= merged_line;
        resp_write_q  <= write_q;
      end
    end
  end

endmodule

// File: tb/tb_memory_bank_pipelined.sv
// tb/tb_memory_bank_pipelined.sv - scoreboard bench for memory_bank_pipelined
// Byte-array reference model feeds an expected-response queue drained by a monitor.
module tb_memory_bank_pipelined;
  localparam int LEN   = 256;
  localparam int AW    = 2;
  localparam int LAT   = 5;
  localparam int NB    = LEN / 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [0:LEN-1]  req_data;
  logic [0:NB-1]   req_be;
  logic            resp_valid;
  logic            resp_write;
  logic [0:LEN-1]  resp_data;

  always #5 clk = ~clk;

  memory_bank_pipelined #(
    .MEMORY_LINE_LENGTH(LEN),
    .MEMORY_ADDRESS_SIZE(AW),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_be(req_be),
    .resp_valid(resp_valid),
    .resp_write(resp_write),
    .resp_data(resp_data)
  );

  typedef struct {
    logic           w;
    logic [0:LEN-1] d;
    int             due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  mem_m [DEPTH][NB];
  int          passes = 0;
  int          checks = 0;
  int          cyc = 0;
  int          run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [LEN-1:0] act, input logic [LEN-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [0:LEN-1] rnd_line();
    logic [0:LEN-1] r;
    for (int i = 0; i < LEN / 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic void model_clear();
    for (int a = 0; a < DEPTH; a++)
      for (int i = 0; i < NB; i++) mem_m[a][i] = 8'h00;
  endfunction

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_write", resp_write, mon_e.w);
        chk("resp_data", resp_data, mon_e.d);
        chk("resp_latency", cyc, mon_e.due);
      end
    end
    if (!rst_n) begin
      run = 0;
    end else if (!req_ready) begin
      run++;
    end else if (run != 0) begin
      chk("ready_low_run", run, LAT + 1);
      run = 0;
    end
  end

  // Caller is just past a negedge; returns just past the negedge after acceptance.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [0:LEN-1] d,
                       input logic [0:NB-1] be, input bit scramble, input bit keep);
    int             waited = 0;
    exp_t           x;
    logic [0:LEN-1] line;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    req_be    = be;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    if (w) begin
      for (int i = 0; i < NB; i++) if (be[i]) mem_m[a][i] = d[8*i +: 8];
    end
    for (int i = 0; i < NB; i++) line[8*i +: 8] = mem_m[a][i];
    x.w   = w;
    x.d   = line;
    x.due = cyc + 1 + LAT;
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    if (scramble) begin
      req_write = 1'($urandom());
      req_addr  = AW'($urandom());
      req_data  = rnd_line();
      req_be    = NB'($urandom());
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [0:LEN-1] d2;
    logic [0:LEN-1] d3;
    logic [0:NB-1]  be;
    int             sel;
    bit             keep;
    d2 = 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;
    d3 = {{28{8'hFF}}, {4{8'h00}}};
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_be    = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_ready", req_ready, 1);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_write", resp_write, 0);
    chk("reset_resp_data", resp_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 2'd1, '0, '1, 1'b0, 1'b0);
    drain();

    issue(1'b1, 2'd3, d2, '1, 1'b0, 1'b0);
    issue(1'b0, 2'd3, '0, '0, 1'b0, 1'b0);
    drain();
    chk("t2_read_line", resp_data, d2);

    issue(1'b1, 2'd2, '1, '1, 1'b0, 1'b0);
    issue(1'b1, 2'd2, '0, 32'h0000_000F, 1'b0, 1'b0);
    issue(1'b0, 2'd2, '0, '0, 1'b0, 1'b0);
    drain();
    chk("t3_partial_be", resp_data, d3);

    for (int k = 0; k < 5; k++)
      issue(1'($urandom()), AW'($urandom()), rnd_line(), NB'($urandom()), 1'b0, k != 4);
    drain();

    for (int k = 0; k < 4; k++)
      issue(1'($urandom()), AW'($urandom()), rnd_line(), NB'($urandom()), 1'b1, 1'b0);
    drain();

    issue(1'b1, 2'd0, rnd_line(), '1, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t6_ready_in_reset", req_ready, 1);
    chk("t6_no_resp_in_reset", resp_valid, 0);
    sb.delete();
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready_after_reset", req_ready, 1);
    repeat (LAT + 2) @(negedge clk);
    issue(1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    drain();
    chk("t6_read_zero", resp_data, 0);

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 3);
      be  = (sel == 0) ? '0 : (sel == 1) ? '1 : NB'($urandom());
      keep = (k != 39) && ($urandom_range(0, 3) == 0);
      issue(1'($urandom()), AW'($urandom()), rnd_line(), be, 1'($urandom()), keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
